// File: rtl/ieee754_convert.sv
// ieee754_convert: multi-cycle converter between signed 32-bit integers and
// IEEE754 single floats. op=0 (FLOAT) turns an int into float bits, op=1 (FTRC)
// turns float bits into an int. Rounding is toward zero, and denormals are read as zero.
// An iterative shifter moves SHIFT_STEP bits per cycle while far from the target
// and 1 bit per cycle when close. Results are packed into a register that
// stays stable for the whole DONE state.
//
// Handshake: a request transfers on the rising edge where in_valid && in_ready.
// A result transfers on the rising edge where out_valid && out_ready. in_ready
// is high only in IDLE. out_valid is high only in DONE. Nothing is accepted on
// the edge that leaves DONE.
module ieee754_convert #(
   parameter int SHIFT_STEP = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_op,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [1:0]  dbg_state
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_NORM = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [8:0] STEP9    = 9'(SHIFT_STEP);
   localparam logic [8:0] EXP_TOP  = 9'd158;   // exponent of a value whose MSB is bit 31

   logic [1:0]  r_state;
   logic        r_op;
   logic        r_sign;
   logic [31:0] r_m;
   logic [8:0]  r_e;          // exponent (FLOAT) or remaining right shift (FTRC)
   logic [31:0] r_out_data;

   logic [31:0] w_abs;
   logic [7:0]  w_ex;
   logic [22:0] w_frac;
   logic        w_coarse_zero;

   // Decode the incoming word and check whether a coarse left shift is safe.
   always_comb begin
      w_abs         = in_data[31] ? (~in_data + 32'd1) : in_data;
      w_ex          = in_data[30:23];
      w_frac        = in_data[22:0];
      w_coarse_zero = (r_m[31:32-SHIFT_STEP] == '0);
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign out_data  = r_out_data;
   assign dbg_state = r_state;

   // Capture a request, run the shifter and hold the result until it is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_op       <= 1'b0;
         r_sign     <= 1'b0;
         r_m        <= '0;
         r_e        <= '0;
         r_out_data <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_op   <= in_op;
                  r_sign <= in_data[31];
                  if (!in_op) begin
                     if (in_data == 32'd0) begin
                        r_out_data <= 32'd0;
                        r_state    <= ST_DONE;
                     end else begin
                        r_m     <= w_abs;
                        r_e     <= EXP_TOP;
                        r_state <= ST_NORM;
                     end
                  end else begin
                     if (w_ex < 8'd127) begin
                        r_out_data <= 32'd0;
                        r_state    <= ST_DONE;
                     end else if (w_ex == 8'd255 && w_frac != 23'd0) begin
                        r_out_data <= 32'h8000_0000;
                        r_state    <= ST_DONE;
                     end else if (w_ex >= 8'd158) begin
                        r_out_data <= in_data[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                        r_state    <= ST_DONE;
                     end else begin
                        r_m     <= {1'b1, w_frac, 8'd0};
                        r_e     <= EXP_TOP - {1'b0, w_ex};
                        r_state <= ST_NORM;
                     end
                  end
               end
            end
            ST_NORM: begin
               if (!r_op) begin
                  // Normalise left until the leading one sits in bit 31.
                  if (w_coarse_zero) begin
                     r_m <= r_m << SHIFT_STEP;
                     r_e <= r_e - STEP9;
                  end else if (!r_m[31]) begin
                     r_m <= r_m << 1;
                     r_e <= r_e - 9'd1;
                  end else begin
                     r_out_data <= {r_sign, r_e[7:0], r_m[30:8]};
                     r_state    <= ST_DONE;
                  end
               end else begin
                  // Denormalise right until the binary point is below bit 0.
                  if (r_e >= STEP9) begin
                     r_m <= r_m >> SHIFT_STEP;
                     r_e <= r_e - STEP9;
                  end else if (r_e != 9'd0) begin
                     r_m <= r_m >> 1;
                     r_e <= r_e - 9'd1;
                  end else begin
                     r_out_data <= r_sign ? (~r_m + 32'd1) : r_m;
                     r_state    <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
